resonant_sys_mc: RTL and testbench

RESONANT_SYS_MC -- requirements
Module: resonant_sys_mc

---
 rtl/resonant_sys_mc.sv | 178 +++++++++++++++++
 tb/tb_resonant_sys_mc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/resonant_sys_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : resonant_sys_mc
// Description : Multi-channel charge-balancing integrator. Each channel adds
//               its unsigned reference to a saturating accumulator. When the
//               accumulator reaches Q_PER_PULSE, one charge quantum is removed
//               and a fixed-width pulse is emitted on q_serialized. Channels
//               share only clk, rst and start.
// Build macro : RESONANT_SYS_MC_COUNT_EN - when defined, each channel has a
//               wrapping pulse counter on pulse_count. When undefined, no
//               counter registers exist and pulse_count reads 0.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               start        - integration enable, shared by all channels
//               i_ref        - N_CH x BUS_WIDTH unsigned references
//               q_serialized - N_CH per-channel pulse outputs
//               pulse_count  - N_CH x CNT_WIDTH per-channel pulse counts
//               overflow     - N_CH sticky accumulator-saturation flags
// Revision    : 1.0 - initial release
// ============================================================================
module resonant_sys_mc #(
    parameter int BUS_WIDTH      = 10,
    parameter int N_CH           = 2,
    parameter int PULSE_DURATION = 3,
    parameter int Q_PER_PULSE    = 60,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_CH*BUS_WIDTH-1:0]   i_ref,
    output logic [N_CH-1:0]             q_serialized,
    output logic [N_CH*CNT_WIDTH-1:0]   pulse_count,
    output logic [N_CH-1:0]             overflow
);

    localparam int ACC_W = BUS_WIDTH + 4;
    localparam int PD_W  = (PULSE_DURATION > 1) ? $clog2(PULSE_DURATION) : 1;

    localparam logic [ACC_W-1:0] C_Q_PER_PULSE = ACC_W'(Q_PER_PULSE);
    localparam logic [PD_W-1:0]  C_PD_LAST     = PD_W'(PULSE_DURATION - 1);
    localparam logic [PD_W-1:0]  C_PD_ONE      = PD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INTEG = 2'd1,
        S_PULSE = 2'd2
    } state_t;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t                 state_q, state_d;
        logic [ACC_W-1:0]       acc_q, acc_d;
        logic [PD_W-1:0]        pcnt_q, pcnt_d;
        logic                   ovf_q, ovf_d;

        logic [BUS_WIDTH-1:0]   w_ref;
        logic [ACC_W:0]         w_sum;
        logic                   w_carry;
        logic [ACC_W-1:0]       w_acc_sat;

        assign w_ref     = i_ref[k*BUS_WIDTH +: BUS_WIDTH];
        // One extra bit catches the carry out so the add can clamp to all-ones.
        assign w_sum     = {1'b0, acc_q} + (ACC_W+1)'(w_ref);
        assign w_carry   = w_sum[ACC_W];
        assign w_acc_sat = w_carry ? '1 : w_sum[ACC_W-1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                pcnt_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                acc_q   <= acc_d;
                pcnt_q  <= pcnt_d;
                ovf_q   <= ovf_d;
            end
        end

        always_comb begin
            state_d = state_q;
            acc_d   = acc_q;
            pcnt_d  = pcnt_q;
            ovf_d   = ovf_q;
            case (state_q)
                S_IDLE: begin
                    acc_d  = '0;
                    pcnt_d = '0;
                    if (start) begin
                        state_d = S_INTEG;
                        ovf_d   = 1'b0;
                    end
                end
                S_INTEG: begin
                    if (!start) begin
                        // Leaving integration discards the accumulator; no
                        // addition happens on this edge.
                        state_d = S_IDLE;
                        acc_d   = '0;
                    end else begin
                        if (w_carry) begin
                            ovf_d = 1'b1;
                        end
                        // Threshold is checked on the clamped value, so a
                        // saturated accumulator still fires every period.
                        if (w_acc_sat >= C_Q_PER_PULSE) begin
                            acc_d   = w_acc_sat - C_Q_PER_PULSE;
                            state_d = S_PULSE;
                            pcnt_d  = '0;
                        end else begin
                            acc_d   = w_acc_sat;
                        end
                    end
                end
                S_PULSE: begin
                    // The pulse always runs to full length; start is only
                    // looked at on its final edge.
                    if (pcnt_q == C_PD_LAST) begin
                        pcnt_d = '0;
                        if (start) begin
                            state_d = S_INTEG;
                            acc_d   = w_acc_sat;
                            if (w_carry) begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            state_d = S_IDLE;
                            acc_d   = '0;
                        end
                    end else begin
                        pcnt_d = pcnt_q + C_PD_ONE;
                        acc_d  = w_acc_sat;
                        if (w_carry) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pcnt_d  = '0;
                end
            endcase
        end

        // Pulse output is a pure decode of the state register, so it is glitch
        // free and rises on the same edge that enters PULSE.
        assign q_serialized[k] = (state_q == S_PULSE);
        assign overflow[k]     = ovf_q;

`ifdef RESONANT_SYS_MC_COUNT_EN
        localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

        logic                   w_fire;
        logic [CNT_WIDTH-1:0]   cnt_q;

        assign w_fire = (state_q == S_INTEG) && (state_d == S_PULSE);

        // Counter wraps naturally and is only cleared by rst, never by start.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (w_fire) begin
                cnt_q <= cnt_q + C_CNT_ONE;
            end
        end

        assign pulse_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`else
        assign pulse_count[k*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_resonant_sys_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_resonant_sys_mc
// Description : Self-checking bench for resonant_sys_mc at default parameters.
//               A vector table covers the basic pulse train, a start drop in
//               the middle of a pulse and a start drop during integration.
//               Hand-written sequences cover asynchronous reset mid-pulse and
//               accumulator saturation with two active channels. Expected
//               pulse counts are zero when RESONANT_SYS_MC_COUNT_EN is
//               undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resonant_sys_mc;

    localparam int BW  = 10;
    localparam int NCH = 2;
    localparam int CW  = 16;
`ifdef RESONANT_SYS_MC_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic [NCH*BW-1:0]  i_ref;
    logic [NCH-1:0]     q_serialized;
    logic [NCH*CW-1:0]  pulse_count;
    logic [NCH-1:0]     overflow;

    int checks;
    int failures;

    resonant_sys_mc dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .i_ref        (i_ref),
        .q_serialized (q_serialized),
        .pulse_count  (pulse_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [1:0] q;
        int         c0;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [1:0] q, input int c0);
        vec_t v;
        v.st = st;
        v.q  = q;
        v.c0 = c0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%0d exp=%0d", nm, idx, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        i_ref    = '0;

        // ch0 i_ref=20, ch1 i_ref=0. Columns: start, expected q, expected cnt0.
        add(1, 2'b00, 0); add(1, 2'b00, 0); add(1, 2'b00, 0); add(1, 2'b01, 1);
        add(1, 2'b01, 1); add(1, 2'b01, 1); add(1, 2'b00, 1); add(1, 2'b01, 2);
        add(1, 2'b01, 2); add(1, 2'b01, 2); add(1, 2'b00, 2); add(1, 2'b01, 3);
        add(1, 2'b01, 3); add(1, 2'b01, 3); add(1, 2'b00, 3); add(1, 2'b01, 4);
        // start drops one cycle into the pulse: pulse completes, then IDLE
        add(0, 2'b01, 4); add(0, 2'b01, 4); add(0, 2'b00, 4); add(0, 2'b00, 4);
        // restart reproduces the original 3-edge latency (acc was cleared)
        add(1, 2'b00, 4); add(1, 2'b00, 4); add(1, 2'b00, 4); add(1, 2'b01, 5);
        add(1, 2'b01, 5); add(1, 2'b01, 5); add(1, 2'b00, 5);
        // start drops during INTEG with acc=60: must clear, not pulse early
        add(0, 2'b00, 5);
        add(1, 2'b00, 5); add(1, 2'b00, 5); add(1, 2'b00, 5); add(1, 2'b01, 6);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 0, 64'(q_serialized), 64'd0);
        chk("reset_cnt", 0, 64'(pulse_count), 64'd0);
        chk("reset_ovf", 0, 64'(overflow), 64'd0);

        @(negedge clk);
        rst   = 1'b0;
        i_ref = {10'd0, 10'd20};

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            start = vecs[i].st;
            @(posedge clk);
            #1;
            chk("tbl_q", i, 64'(q_serialized), 64'(vecs[i].q));
            chk("tbl_cnt0", i, 64'(pulse_count[CW-1:0]), 64'(vecs[i].c0 * CNT_ON));
            chk("tbl_cnt1", i, 64'(pulse_count[2*CW-1:CW]), 64'd0);
            chk("tbl_ovf", i, 64'(overflow), 64'd0);
        end

        // Asynchronous reset in the middle of a pulse, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_q", 0, 64'(q_serialized), 64'd0);
        chk("rst_mid_cnt", 0, 64'(pulse_count), 64'd0);
        chk("rst_mid_ovf", 0, 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            chk("post_rst_q", e, 64'(q_serialized), (e == 3) ? 64'd1 : 64'd0);
            chk("post_rst_cnt0", e, 64'(pulse_count[CW-1:0]),
                (e == 3) ? 64'(CNT_ON) : 64'd0);
        end

        // Saturation: ch0 i_ref=1023 overflows at E17, ch1 i_ref=30 pulses
        // from E2 every 4 edges and never overflows.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        i_ref = {10'd30, 10'd1023};
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 28; e++) begin
            if (e != 0) @(negedge clk);
            start = (e == 25 || e == 26) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (e <= 24) begin
                chk("sat_q0", e, 64'(q_serialized[0]),
                    (e >= 1 && (e % 4) != 0) ? 64'd1 : 64'd0);
                chk("sat_q1", e, 64'(q_serialized[1]),
                    (e >= 2 && ((e - 2) % 4) != 3) ? 64'd1 : 64'd0);
                chk("sat_ovf", e, 64'(overflow), (e >= 17) ? 64'd1 : 64'd0);
                chk("sat_cnt0", e, 64'(pulse_count[CW-1:0]),
                    (e >= 1) ? 64'(((e + 3) / 4) * CNT_ON) : 64'd0);
                chk("sat_cnt1", e, 64'(pulse_count[2*CW-1:CW]),
                    64'(((e + 2) / 4) * CNT_ON));
            end else begin
                // Overflow survives IDLE and is cleared only by IDLE->INTEG.
                chk("ovf_clr_q0", e, 64'(q_serialized[0]), (e == 28) ? 64'd1 : 64'd0);
                chk("ovf_clr_ovf0", e, 64'(overflow[0]), (e <= 26) ? 64'd1 : 64'd0);
                chk("ovf_clr_cnt0", e, 64'(pulse_count[CW-1:0]),
                    64'(((e == 28) ? 7 : 6) * CNT_ON));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
